// File: rtl/arm7tdmi_shift_pipe.sv
// arm7tdmi_shift_pipe: pipelined ARM barrel shifter with valid/ready flow control.
// Implements the full ARM shifter-operand rules for immediate and register shift
// amounts, including amounts at or beyond WIDTH, and a synchronous flush.
// LATENCY=1 does everything in one registered stage. LATENCY=2 splits the work:
// decode plus the coarse shift in stage 1, then the fine shift and flags in stage 2.
// Optional macro ARM7TDMI_SHIFT_FLAGS_EN adds registered N/Z flags; without it,
// out_n and out_z are tied to 0.

module arm7tdmi_shift_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_type,
    input  logic [7:0]       in_amount,
    input  logic             in_imm,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_n,
    output logic             out_z
);

    localparam int L  = $clog2(WIDTH);
    localparam int LO = L / 2;

    typedef enum logic [1:0] {
        K_LSL = 2'b00,
        K_LSR = 2'b01,
        K_ASR = 2'b10,
        K_ROR = 2'b11
    } kind_e;

    typedef logic [L-1:0]     amt_t;
    typedef logic [WIDTH-1:0] word_t;

    localparam logic [7:0] W8        = 8'(WIDTH);
    localparam amt_t       FINE_MASK = amt_t'((1 << LO) - 1);

    // Shift or rotate x by n, where n is in 0..WIDTH-1. The coarse and fine steps
    // compose because each kind of shift is additive in its amount.
    function automatic word_t do_shift(input kind_e k, input word_t x, input amt_t n);
        word_t r;
        case (k)
            K_LSL:   r = x << n;
            K_LSR:   r = x >> n;
            K_ASR:   r = word_t'($signed(x) >>> n);
            default: r = (x >> n) | (x << (WIDTH - int'(n)));
        endcase
        return r;
    endfunction

    // Decode results: every out-of-range case becomes a substituted operand with a zero shift.
    logic [7:0] amt_raw;
    logic [7:0] amt;
    word_t      dec_src;
    kind_e      dec_kind;
    amt_t       dec_sh;
    logic       dec_carry;
    amt_t       coarse_n;
    amt_t       fine_n;
    word_t      coarse_data;

    // Signals seen by the final stage, either registered (LATENCY=2) or direct (LATENCY=1).
    logic       st_valid;
    word_t      st_data;
    kind_e      st_kind;
    amt_t       st_fine;
    logic       st_carry;

    logic       accept;
    logic       out_adv;
    logic       out_load;
    word_t      fin_data;

    logic       out_valid_q, out_valid_d;
    word_t      out_data_q, out_data_d;
    logic       out_carry_q, out_carry_d;

    // Immediate encodings use only the low L bits; #0 means #WIDTH for LSR and ASR.
    assign amt_raw = in_imm ? 8'(in_amount[L-1:0]) : in_amount;
    assign amt     = (in_imm && amt_raw == 8'd0 &&
                      (in_type == K_LSR || in_type == K_ASR)) ? W8 : amt_raw;

    assign accept  = in_valid && in_ready;
    assign out_adv = !out_valid_q || out_ready;

    // Map the operation onto (operand, kind, amount < WIDTH, carry-out).
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dec_src   = in_data;
        dec_kind  = K_LSL;
        dec_sh    = '0;
        dec_carry = in_carry;
        if (in_imm && amt == 8'd0 && in_type == K_ROR) begin
            dec_src   = {in_carry, in_data[WIDTH-1:1]};
            dec_carry = in_data[0];
        end else if (amt != 8'd0) begin
            case (kind_e'(in_type))
                K_LSL: begin
                    if (amt < W8) begin
                        dec_sh    = amt_t'(amt);
                        dec_carry = in_data[amt_t'(W8 - amt)];
                    end else begin
                        dec_src   = '0;
                        dec_carry = (amt == W8) ? in_data[0] : 1'b0;
                    end
                end
                K_LSR: begin
                    if (amt < W8) begin
                        dec_kind  = K_LSR;
                        dec_sh    = amt_t'(amt);
                        dec_carry = in_data[amt_t'(amt - 8'd1)];
                    end else begin
                        dec_src   = '0;
                        dec_carry = (amt == W8) ? in_data[WIDTH-1] : 1'b0;
                    end
                end
                K_ASR: begin
                    if (amt < W8) begin
                        dec_kind  = K_ASR;
                        dec_sh    = amt_t'(amt);
                        dec_carry = in_data[amt_t'(amt - 8'd1)];
                    end else begin
                        dec_src   = {WIDTH{in_data[WIDTH-1]}};
                        dec_carry = in_data[WIDTH-1];
                    end
                end
                K_ROR: begin
                    if (amt[L-1:0] == '0) begin
                        dec_carry = in_data[WIDTH-1];
                    end else begin
                        dec_kind  = K_ROR;
                        dec_sh    = amt[L-1:0];
                        dec_carry = in_data[amt[L-1:0] - amt_t'(1)];
                    end
                end
            endcase
        end
    end

    assign coarse_n    = dec_sh & ~FINE_MASK;
    assign fine_n      = dec_sh & FINE_MASK;
    assign coarse_data = do_shift(dec_kind, dec_src, coarse_n);

    generate
        if (LATENCY == 2) begin : g_two_stage
            logic  s1_valid_q, s1_valid_d;
            word_t s1_data_q, s1_data_d;
            kind_e s1_kind_q, s1_kind_d;
            amt_t  s1_fine_q, s1_fine_d;
            logic  s1_carry_q, s1_carry_d;

            assign in_ready = !flush && (!s1_valid_q || out_adv);

            // Stage 1 holds the decoded, coarsely shifted operand until stage 2 takes it.
            always_comb begin
                s1_valid_d = s1_valid_q;
                s1_data_d  = s1_data_q;
                s1_kind_d  = s1_kind_q;
                s1_fine_d  = s1_fine_q;
                s1_carry_d = s1_carry_q;
                if (flush) begin
                    s1_valid_d = 1'b0;
                end else if (accept) begin
                    s1_valid_d = 1'b1;
                end else if (out_adv) begin
                    s1_valid_d = 1'b0;
                end
                if (accept) begin
                    s1_data_d  = coarse_data;
                    s1_kind_d  = dec_kind;
                    s1_fine_d  = fine_n;
                    s1_carry_d = dec_carry;
                end
            end

            // Stage 1 register.
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                    s1_kind_q  <= K_LSL;
                    s1_fine_q  <= '0;
                    s1_carry_q <= 1'b0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                    s1_data_q  <= s1_data_d;
                    s1_kind_q  <= s1_kind_d;
                    s1_fine_q  <= s1_fine_d;
                    s1_carry_q <= s1_carry_d;
                end
            end

            assign st_valid = s1_valid_q;
            assign st_data  = s1_data_q;
            assign st_kind  = s1_kind_q;
            assign st_fine  = s1_fine_q;
            assign st_carry = s1_carry_q;
        end else begin : g_one_stage
            assign in_ready = !flush && out_adv;
            assign st_valid = in_valid;
            assign st_data  = coarse_data;
            assign st_kind  = dec_kind;
            assign st_fine  = fine_n;
            assign st_carry = dec_carry;
        end
    endgenerate

    assign fin_data = do_shift(st_kind, st_data, st_fine);
    assign out_load = st_valid && out_adv && !flush;

    // Output stage: loads when the result can advance, holds steady while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_carry_d = out_carry_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (out_load) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (out_load) begin
            out_data_d  = fin_data;
            out_carry_d = st_carry;
        end
    end

    // Output register.
    // NOTE: data flops are reset too, so out_data/out_carry read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_carry_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_carry_q <= out_carry_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_carry = out_carry_q;

`ifdef ARM7TDMI_SHIFT_FLAGS_EN
    logic out_n_q, out_n_d;
    logic out_z_q, out_z_d;

    // Flags are derived from the final result and registered alongside it.
    always_comb begin
        out_n_d = out_n_q;
        out_z_d = out_z_q;
        if (out_load) begin
            out_n_d = fin_data[WIDTH-1];
            out_z_d = (fin_data == '0);
        end
    end

    // Flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_n_q <= 1'b0;
            out_z_q <= 1'b0;
        end else begin
            out_n_q <= out_n_d;
            out_z_q <= out_z_d;
        end
    end

    assign out_n = out_n_q;
    assign out_z = out_z_q;
`else
    assign out_n = 1'b0;
    assign out_z = 1'b0;
`endif

endmodule

// File: doc/arm7tdmi_shift_pipe.md
# arm7tdmi_shift_pipe

Parametrised, pipelined ARM barrel shifter with valid/ready flow control. It sits between operand fetch and the ALU. It implements full ARM shifter-operand semantics for both immediate-specified and register-specified shift amounts, including the amount ≥ WIDTH cases. It computes a result and a shifter carry-out per accepted operation and supports a pipeline flush.

## Interface
- WIDTH, 32, data width; a power of two, 8..64.
- LATENCY, 1, register stages from accept to result; legal values 1 or 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards all in-flight operations.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_data  in  WIDTH  operand.
- in_type  in  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- in_amount  in  8  shift amount; register mode uses all 8 bits.
- in_imm  in  1  1 = immediate encoding; 0 = register-specified.
- in_carry  in  1  current C flag.
- out_valid  out  1  result present.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  WIDTH  shifted result.
- out_carry  out  1  shifter carry-out.
- out_n  out  1  out_data[WIDTH-1]; 0 when ARM7TDMI_SHIFT_FLAGS_EN is absent.
- out_z  out  1  out_data == 0; 0 when ARM7TDMI_SHIFT_FLAGS_EN is absent.

## Operation
- Let L = log2(WIDTH) and a = in_amount.
- **Immediate mode (in_imm=1).** Only a[L-1:0] is used, and a = a[L-1:0].
  - LSL #0: passthrough, carry = in_carry.
  - LSR #0 is treated as LSR #WIDTH.
  - ASR #0 is treated as ASR #WIDTH.
  - ROR #0 is RRX: data = {in_carry, in_data[WIDTH-1:1]}, carry = in_data[0].
- **Register mode (in_imm=0), a = 0, any type:** passthrough, carry = in_carry.
- **LSL**
  - a < WIDTH: data << a, carry = in_data[WIDTH-a].
  - a = WIDTH: data 0, carry = in_data[0].
  - a > WIDTH: data 0, carry 0.
- **LSR**
  - a < WIDTH: data >> a, carry = in_data[a-1].
  - a = WIDTH: data 0, carry = in_data[WIDTH-1].
  - a > WIDTH: data 0, carry 0.
- **ASR**
  - a < WIDTH: arithmetic shift, carry = in_data[a-1].
  - a ≥ WIDTH: all bits = in_data[WIDTH-1], carry = in_data[WIDTH-1].
- **ROR (register mode, a ≠ 0)**
  - Let r = a mod WIDTH.
  - r = 0: data unchanged, carry = in_data[WIDTH-1].
  - Otherwise: rotate right by r, carry = result[WIDTH-1].
- **Flow control**
  - Each stage holds a valid bit and the stage payload.
  - A stage loads when it is empty or its downstream consumer is ready.
  - in_ready = !stage1_valid || stage1 advancing. This is combinational from out_ready; there is no skid buffer.
  - Full throughput: one operation per cycle when out_ready stays high.
  - While out_valid && !out_ready, all out_* outputs hold stable.
- **Flush**
  - All valid bits clear at the next edge.
  - An operation offered in the same cycle as flush is not accepted; in_ready = 0 while flush = 1.
  - Data registers are not cleared.
- **LATENCY = 2 split**
  - Stage 1 decodes type and amount: immediate remap, ≥ WIDTH classification, carry-out selection. It also applies the coarse shift on a[L-1:L/2].
  - Stage 2 applies the fine shift and computes the flags.
- **LATENCY = 1:** all of the above completes in a single registered stage.

## Timing
- Reset (async assert, sync release):
  - all valid bits = 0, so out_valid = 0;
  - out_data = 0, out_carry = 0, out_n = 0, out_z = 0;
  - in_ready = 1 from the first cycle after release.
- Operation accepted at edge k appears with out_valid = 1 after edge k+LATENCY-1, i.e. visible in cycle k+LATENCY when unstalled.
- Reset mid-operation drops all in-flight operations without producing output.
- Back-pressure with a full pipe: accept and consume in the same cycle is legal, with no bubble.

## Configuration
- ARM7TDMI_SHIFT_FLAGS_EN defined:
  - out_n and out_z are registered alongside out_data;
  - when LATENCY = 2 they are computed in stage 2.
- Undefined: out_n and out_z are tied to 0 and no flag logic is instantiated. The port list is identical in both builds.

## Test plan
- WIDTH=32, in_imm=1, LSR, in_amount=0, in_data=0x80000001 -> out_data=0x00000000, out_carry=1.
- in_imm=1, ROR, in_amount=0, in_carry=1, in_data=0x00000003 -> out_data=0x80000001, out_carry=1.
- Register mode, in_data=0x80000001:
  - LSL by 32 -> data 0, carry 1;
  - LSL by 33 -> data 0, carry 0;
  - ASR by 200 -> 0xFFFFFFFF, carry 1;
  - ROR by 64 -> data unchanged, carry 1.
- LATENCY=2, issue 4 back-to-back operations with out_ready held low for 3 cycles from cycle 2 -> in_ready drops when both stages are full; all 4 results arrive in order with no loss or duplication; outputs stable while stalled.
- Flush asserted while 2 operations are in flight and in_valid=1 -> in_ready=0 that cycle; out_valid=0 next cycle; the next accepted operation emerges after exactly LATENCY cycles.
- rst_n pulsed low mid-stream -> out_valid=0 and out_data=0 immediately (async); in_ready=1 after release; with ARM7TDMI_SHIFT_FLAGS_EN, LSL of 0x40000000 by 1 -> out_n=1, out_z=0.
